trig_lookup_arbiter: RTL and testbench

- Shares one dual-port cosine ROM (360 entries, 11-bit signed, Q9 so 512 = 1.0) among NUM_REQ requesters, e.g. player kart, opponent kart and collision logic.
- Each granted request returns cos(angle) and sin(angle) a fixed ROM_LATENCY cycles later.
- Replaces per-kart ROM instances and hard-coded hcount/vcount timing with a valid/ready interface and a round-robin arbiter.

---
 rtl/trig_lookup_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_trig_lookup_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_lookup_arbiter.sv
// Round-robin arbiter sharing one dual-port cosine ROM (Q9) among NUM_REQ requesters.
// Define TRIG_VELOCITY_SCALE_EN to add speed-scaled velocity outputs (one extra cycle of latency).
module trig_lookup_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ROM_LATENCY = 2,
    parameter int ANGLE_W     = 9,
    parameter int DATA_W      = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ANGLE_W-1:0] req_angle,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [ANGLE_W-1:0]         rom_addra,
    output logic [ANGLE_W-1:0]         rom_addrb,
    input  logic signed [DATA_W-1:0]   rom_douta,
    input  logic signed [DATA_W-1:0]   rom_doutb,
`ifdef TRIG_VELOCITY_SCALE_EN
    input  logic [10:0]                speed,
    output logic signed [11:0]         resp_vx,
    output logic signed [11:0]         resp_vy,
`endif
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic signed [DATA_W-1:0]   resp_cos,
    output logic signed [DATA_W-1:0]   resp_sin,
    output logic                       busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int L     = ROM_LATENCY;

    logic [ANGLE_W-1:0] angle_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign angle_arr[gi] = req_angle[gi*ANGLE_W +: ANGLE_W];
        end
    endgenerate

    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] grant_idx, cand;
    logic             grant_any;

    // Search begins one past the last grant so every requester gets a turn.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last_grant_q;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (rst) begin
            grant_any = 1'b0;
        end
        req_ready    = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
        last_grant_d = grant_any ? grant_idx : last_grant_q;
    end

    logic [ANGLE_W-1:0] sel_angle, norm_angle;
    logic [ANGLE_W-1:0] addra_q, addra_d, addrb_q, addrb_d;

    // Port B reads cos(|a-90|), which equals sin(a) for 0 <= a < 360.
    always_comb begin
        sel_angle  = angle_arr[grant_idx];
        norm_angle = (sel_angle >= ANGLE_W'(360)) ? sel_angle - ANGLE_W'(360) : sel_angle;
        addra_d    = addra_q;
        addrb_d    = addrb_q;
        if (rst) begin
            addra_d = '0;
            addrb_d = '0;
        end else if (grant_any) begin
            addra_d = norm_angle;
            addrb_d = (norm_angle >= ANGLE_W'(90)) ? norm_angle - ANGLE_W'(90)
                                                   : ANGLE_W'(90) - norm_angle;
        end
    end

    assign rom_addra = addra_d;
    assign rom_addrb = addrb_d;

    logic [L-1:0]       pipe_vld_q, pipe_vld_d;
    logic [NUM_REQ-1:0] pipe_id_q [L];
    logic [NUM_REQ-1:0] pipe_id_d [L];
`ifdef TRIG_VELOCITY_SCALE_EN
    logic [10:0]        pipe_spd_q [L];
    logic [10:0]        pipe_spd_d [L];
`endif

    always_comb begin
        pipe_vld_d    = '0;
        pipe_id_d     = '{default: '0};
        pipe_vld_d[0] = grant_any;
        pipe_id_d[0]  = req_ready;
`ifdef TRIG_VELOCITY_SCALE_EN
        pipe_spd_d    = '{default: '0};
        pipe_spd_d[0] = speed;
`endif
        for (int s = 1; s < L; s++) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            pipe_id_d[s]  = pipe_id_q[s-1];
`ifdef TRIG_VELOCITY_SCALE_EN
            pipe_spd_d[s] = pipe_spd_q[s-1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            addra_q      <= '0;
            addrb_q      <= '0;
            pipe_vld_q   <= '0;
            for (int s = 0; s < L; s++) begin
                pipe_id_q[s] <= '0;
`ifdef TRIG_VELOCITY_SCALE_EN
                pipe_spd_q[s] <= '0;
`endif
            end
        end else begin
            last_grant_q <= last_grant_d;
            addra_q      <= addra_d;
            addrb_q      <= addrb_d;
            pipe_vld_q   <= pipe_vld_d;
            for (int s = 0; s < L; s++) begin
                pipe_id_q[s] <= pipe_id_d[s];
`ifdef TRIG_VELOCITY_SCALE_EN
                pipe_spd_q[s] <= pipe_spd_d[s];
`endif
            end
        end
    end

    logic               tail_vld;
    logic [NUM_REQ-1:0] tail_id;
    assign tail_vld = pipe_vld_q[L-1];
    assign tail_id  = pipe_id_q[L-1];

`ifdef TRIG_VELOCITY_SCALE_EN
    // Divide by 512 rounding toward zero, matching signed integer division.
    function automatic logic signed [11:0] scale_q9(input logic signed [23:0] p);
        logic [23:0] mag;
        mag = p[23] ? 24'(-p) : 24'(p);
        mag = mag >> 9;
        return p[23] ? 12'(-mag) : 12'(mag);
    endfunction

    logic                     out_vld_q, out_vld_d;
    logic [NUM_REQ-1:0]       out_id_q, out_id_d;
    logic signed [DATA_W-1:0] out_cos_q, out_cos_d, out_sin_q, out_sin_d;
    logic signed [11:0]       out_vx_q, out_vx_d, out_vy_q, out_vy_d;
    logic signed [23:0]       spd_s, cos_s, sin_s;

    always_comb begin
        spd_s     = 24'($signed({1'b0, pipe_spd_q[L-1]}));
        cos_s     = 24'(rom_douta);
        sin_s     = 24'(rom_doutb);
        out_vld_d = tail_vld;
        out_id_d  = '0;
        out_cos_d = '0;
        out_sin_d = '0;
        out_vx_d  = '0;
        out_vy_d  = '0;
        if (tail_vld) begin
            out_id_d  = tail_id;
            out_cos_d = rom_douta;
            out_sin_d = rom_doutb;
            out_vx_d  = scale_q9(spd_s * cos_s);
            out_vy_d  = 12'(-scale_q9(spd_s * sin_s));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            out_id_q  <= '0;
            out_cos_q <= '0;
            out_sin_q <= '0;
            out_vx_q  <= '0;
            out_vy_q  <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_id_q  <= out_id_d;
            out_cos_q <= out_cos_d;
            out_sin_q <= out_sin_d;
            out_vx_q  <= out_vx_d;
            out_vy_q  <= out_vy_d;
        end
    end

    always_comb begin
        resp_valid = '0;
        resp_cos   = '0;
        resp_sin   = '0;
        resp_vx    = '0;
        resp_vy    = '0;
        busy       = 1'b0;
        if (!rst) begin
            busy = (|pipe_vld_q) | out_vld_q;
            if (out_vld_q) begin
                resp_valid = out_id_q;
                resp_cos   = out_cos_q;
                resp_sin   = out_sin_q;
                resp_vx    = out_vx_q;
                resp_vy    = out_vy_q;
            end
        end
    end
`else
    // ROM data is forwarded unregistered in the cycle the lookup completes.
    always_comb begin
        resp_valid = '0;
        resp_cos   = '0;
        resp_sin   = '0;
        busy       = 1'b0;
        if (!rst) begin
            busy = |pipe_vld_q;
            if (tail_vld) begin
                resp_valid = tail_id;
                resp_cos   = rom_douta;
                resp_sin   = rom_doutb;
            end
        end
    end
`endif

endmodule

// File: tb/tb_trig_lookup_arbiter.sv
// Bench for trig_lookup_arbiter: cosine ROM model, directed steps, then randomized traffic
// checked against a trig/queue reference model.
module tb_trig_lookup_arbiter;
`ifdef TRIG_VELOCITY_SCALE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam real PI = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         req_valid;
    logic [35:0]        req_angle;
    logic [3:0]         req_ready;
    logic [8:0]         rom_addra, rom_addrb;
    logic signed [10:0] rom_douta, rom_doutb, rom_a1, rom_b1;
    logic [3:0]         resp_valid;
    logic signed [10:0] resp_cos, resp_sin;
    logic               busy;
    logic [10:0]        speed;
`ifdef TRIG_VELOCITY_SCALE_EN
    logic signed [11:0] resp_vx, resp_vy;
`endif

    trig_lookup_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_angle  (req_angle),
        .req_ready  (req_ready),
        .rom_addra  (rom_addra),
        .rom_addrb  (rom_addrb),
        .rom_douta  (rom_douta),
        .rom_doutb  (rom_doutb),
`ifdef TRIG_VELOCITY_SCALE_EN
        .speed      (speed),
        .resp_vx    (resp_vx),
        .resp_vy    (resp_vy),
`endif
        .resp_valid (resp_valid),
        .resp_cos   (resp_cos),
        .resp_sin   (resp_sin),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cos_tab [360];

    // Two-cycle synchronous dual-port ROM.
    always @(posedge clk) begin
        rom_a1    <= 11'(cos_tab[rom_addra]);
        rom_b1    <= 11'(cos_tab[rom_addrb]);
        rom_douta <= rom_a1;
        rom_doutb <= rom_b1;
    end

    typedef struct {
        int due;
        int gcyc;
        int id;
        int ang;
        int spd;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   lg          = 3;
    int   hold_a      = 0;
    int   hold_b      = 0;
    int   hs          = -1;

    function automatic int rnd(real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, expv);
        end
    endtask

    task automatic set_angle(int i, int a);
        req_angle = (req_angle & ~(36'h1FF << (i * 9))) | (36'(a & 9'h1FF) << (i * 9));
    endtask

    // Inputs are applied just after a falling edge; this checks one cycle and advances.
    task automatic do_cycle();
        int g, a, fi, c, s, idx;
        logic [3:0] exp_ready, exp_resp;
        logic exp_busy;
        exp_t e;
        #1;
        g = -1;
        a = 0;
        if (!rst) begin
            for (int k = 1; k <= 4; k++) begin
                idx = (lg + k) % 4;
                if (g < 0 && req_valid[2'(idx)]) g = idx;
            end
        end
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0;
        if (rst) begin
            hold_a = 0;
            hold_b = 0;
        end else if (g >= 0) begin
            a = int'((req_angle >> (g * 9)) & 36'h1FF);
            if (a >= 360) a -= 360;
            hold_a = a;
            hold_b = (a >= 90) ? a - 90 : 90 - a;
        end
        fi = -1;
        foreach (q[i]) if (q[i].due == cyc) fi = i;
        exp_resp = 4'b0;
        exp_busy = 1'b0;
        if (!rst) begin
            foreach (q[i]) if (q[i].gcyc < cyc) exp_busy = 1'b1;
            if (fi >= 0) exp_resp = 4'(1 << q[fi].id);
        end
        chk("req_ready", req_ready, exp_ready);
        chk("rom_addra", rom_addra, hold_a);
        chk("rom_addrb", rom_addrb, hold_b);
        chk("resp_valid", resp_valid, exp_resp);
        chk("busy", busy, exp_busy);
        if (rst) begin
            chk("resp_cos_rst", resp_cos, 0);
            chk("resp_sin_rst", resp_sin, 0);
        end else if (fi >= 0) begin
            c = rnd(512.0 * $cos(q[fi].ang * PI / 180.0));
            s = rnd(512.0 * $sin(q[fi].ang * PI / 180.0));
            chk("resp_cos", resp_cos, c);
            chk("resp_sin", resp_sin, s);
`ifdef TRIG_VELOCITY_SCALE_EN
            chk("resp_vx", resp_vx, (q[fi].spd * c) / 512);
            chk("resp_vy", resp_vy, -((q[fi].spd * s) / 512));
`endif
        end
        if (fi >= 0) q.delete(fi);
        if (rst) begin
            q.delete();
            lg = 3;
        end else if (g >= 0) begin
            lg     = g;
            e.due  = cyc + LAT;
            e.gcyc = cyc;
            e.id   = g;
            e.ang  = a;
            e.spd  = int'(speed);
            q.push_back(e);
        end
        hs = g;
        cyc++;
        @(negedge clk);
    endtask

    // mode 0: granted requester drops; 1: it stays valid with a new angle; 2: random traffic.
    task automatic run(int n, int mode);
        for (int i = 0; i < n; i++) begin
            do_cycle();
            if (hs >= 0) begin
                if (mode == 0) begin
                    req_valid[2'(hs)] = 1'b0;
                end else begin
                    req_valid[2'(hs)] = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                    set_angle(hs, $urandom_range(0, 511));
                end
            end
            if (mode == 2) begin
                for (int j = 0; j < 4; j++) begin
                    if (!req_valid[2'(j)] && $urandom_range(0, 3) == 0) begin
                        req_valid[2'(j)] = 1'b1;
                        set_angle(j, $urandom_range(0, 511));
                    end
                end
                speed = 11'($urandom_range(0, 2047));
                rst   = ($urandom_range(0, 63) == 0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 360; i++) cos_tab[i] = rnd(512.0 * $cos(i * PI / 180.0));
        rst       = 1'b1;
        req_valid = 4'b0;
        req_angle = 36'b0;
        speed     = 11'd0;
        run(3, 0);
        rst = 1'b0;
        run(2, 0);

        // All four requesters at once: grants 0..3 in order, responses follow.
        for (int i = 0; i < 4; i++) set_angle(i, 30 * i + 10);
        req_valid = 4'b1111;
        run(8, 0);

        // Requester 0: angles 0, 90, 270.
        set_angle(0, 0);   req_valid = 4'b0001; run(4, 0);
        set_angle(0, 90);  req_valid = 4'b0001; run(4, 0);
        set_angle(0, 270); req_valid = 4'b0001; run(4, 0);

        // Requester 1: angle 400 folds to 40.
        set_angle(1, 400); req_valid = 4'b0010; run(4, 0);

        // Last grant is 1, so requester 2 beats requester 0.
        set_angle(0, 123); set_angle(2, 359);
        req_valid = 4'b0101;
        run(4, 0);

        // Requester 3 alone, granted every cycle with overlapping responses.
        set_angle(3, 45);
        req_valid = 4'b1000;
        run(5, 1);
        req_valid = 4'b0;
        run(4, 0);

        // Reset with a lookup in flight; then index 0 wins first.
        set_angle(0, 30); req_valid = 4'b0001;
        run(1, 0);
        rst = 1'b1; req_valid = 4'b0;
        run(1, 0);
        rst = 1'b0;
        run(3, 0);
        for (int i = 0; i < 4; i++) set_angle(i, 500 - 17 * i);
        req_valid = 4'b1111;
        run(8, 0);

`ifdef TRIG_VELOCITY_SCALE_EN
        speed = 11'd6;
        set_angle(0, 0);   req_valid = 4'b0001; run(5, 0);
        set_angle(0, 90);  req_valid = 4'b0001; run(5, 0);
        set_angle(0, 180); req_valid = 4'b0001; run(5, 0);
`endif

        run(400, 2);
        rst       = 1'b0;
        req_valid = 4'b0;
        run(6, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
